// File: rtl/lsu_pkg.sv
// Shared types for the memory-stage load/store unit.
//   mem_op_e    : operation class presented by EX (reserved encoding behaves as NONE)
//   mem_size_e  : access width B/H/W/D
//   lsu_state_e : memory-stage FSM state
//   size_mask   : byte-lane mask for an access width, right-aligned
package lsu_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_RSVD  = 2'd3
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } lsu_state_e;

  function automatic logic [7:0] size_mask(input mem_size_e size);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane alignment for the load/store unit.
//   size, off, is_unsigned : access width, byte offset within the data word, zero-extend select
//   wdata / wdata_sh       : right-aligned store data in, lane-shifted store data out
//   wstrb                  : byte strobes for the access
//   rdata / rdata_ext      : aligned read word in, shifted and sign/zero-extended load data out
//   misalign               : address not a multiple of the access size (or D on a 32-bit datapath)
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int STRB_W = XLEN / 8,
  localparam int OFF_W = $clog2(STRB_W)
) (
  input  mem_size_e          size,
  input  logic [OFF_W-1:0]   off,
  input  logic               is_unsigned,
  input  logic [XLEN-1:0]    wdata,
  input  logic [XLEN-1:0]    rdata,
  output logic [STRB_W-1:0]  wstrb,
  output logic [XLEN-1:0]    wdata_sh,
  output logic [XLEN-1:0]    rdata_ext,
  output logic               misalign
);

  logic [XLEN-1:0] rsh;
  logic            fill;
  int unsigned     nbits;

  always_comb begin
    wstrb    = STRB_W'(size_mask(size)) << off;
    wdata_sh = wdata << {off, 3'b000};
    rsh      = rdata >> {off, 3'b000};

    misalign = 1'b0;
    nbits    = XLEN;
    fill     = 1'b0;
    case (size)
      SZ_B: begin
        nbits = 8;
        fill  = rsh[7];
      end
      SZ_H: begin
        nbits    = 16;
        fill     = rsh[15];
        misalign = off[0];
      end
      SZ_W: begin
        nbits    = 32;
        fill     = rsh[31];
        misalign = |off[1:0];
      end
      default: begin
        nbits    = XLEN;
        fill     = rsh[XLEN-1];
        // A doubleword cannot be carried on a 32-bit datapath; trap it like a misalignment.
        misalign = (XLEN != 64) || (|off);
      end
    endcase
    if (is_unsigned) fill = 1'b0;

    rdata_ext = '0;
    for (int unsigned i = 0; i < XLEN; i++) begin
      rdata_ext[i] = (i < nbits) ? rsh[i] : fill;
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage (EX -> WB) with a load/store unit.
//   clk, rst                : clock, synchronous active-high reset
//   ex_*/mem_*/rd_w_*_i     : instruction from EX with valid/ready handshake
//   dreq_*                  : data-memory request channel (valid/ready)
//   drsp_*                  : data-memory response channel (one valid cycle per request)
//   wb_valid_o, rd_w_*_o    : one-entry output register towards WB
//   misalign_o              : retiring load/store was misaligned (no memory access made)
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int ADDR_W  = 64,
  parameter int RADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid_i,
  output logic                ex_ready_o,
  input  logic [1:0]          mem_op_i,
  input  logic [1:0]          mem_size_i,
  input  logic                mem_unsigned_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]     mem_wdata_i,
  input  logic                rd_w_ena_i,
  input  logic [RADDR_W-1:0]  rd_w_addr_i,
  input  logic [XLEN-1:0]     rd_w_data_i,
  output logic                dreq_valid_o,
  input  logic                dreq_ready_i,
  output logic                dreq_we_o,
  output logic [ADDR_W-1:0]   dreq_addr_o,
  output logic [XLEN-1:0]     dreq_wdata_o,
  output logic [XLEN/8-1:0]   dreq_wstrb_o,
  input  logic                drsp_valid_i,
  input  logic [XLEN-1:0]     drsp_rdata_i,
  output logic                wb_valid_o,
  output logic                rd_w_ena_o,
  output logic [RADDR_W-1:0]  rd_w_addr_o,
  output logic [XLEN-1:0]     rd_w_data_o,
  output logic                misalign_o
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  lsu_state_e state, state_nxt;

  mem_op_e op;
  logic    accept;
  logic    is_mem;
  logic    start_mem;
  logic    rsp_fire;

  // Operands kept for the response phase.
  logic               lat_load;
  mem_size_e          lat_size;
  logic               lat_uns;
  logic [OFF_W-1:0]   lat_off;
  logic               lat_ena;
  logic [RADDR_W-1:0] lat_raddr;

  mem_size_e         al_size;
  logic [OFF_W-1:0]  al_off;
  logic              al_uns;
  logic [STRB_W-1:0] al_wstrb;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_rdata;
  logic              al_misalign;

  // One aligner serves both phases: in IDLE it sees the incoming instruction
  // (store lanes, misalign check), afterwards the latched operands (load extension).
  always_comb begin
    if (state == ST_IDLE) begin
      al_size = mem_size_e'(mem_size_i);
      al_off  = mem_addr_i[OFF_W-1:0];
      al_uns  = mem_unsigned_i;
    end else begin
      al_size = lat_size;
      al_off  = lat_off;
      al_uns  = lat_uns;
    end
  end

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .size        (al_size),
    .off         (al_off),
    .is_unsigned (al_uns),
    .wdata       (mem_wdata_i),
    .rdata       (drsp_rdata_i),
    .wstrb       (al_wstrb),
    .wdata_sh    (al_wdata),
    .rdata_ext   (al_rdata),
    .misalign    (al_misalign)
  );

  always_comb begin
    op        = mem_op_e'(mem_op_i);
    is_mem    = (op == OP_LOAD) || (op == OP_STORE);
    state_nxt = state;
    ex_ready_o   = 1'b0;
    dreq_valid_o = 1'b0;
    accept    = 1'b0;
    start_mem = 1'b0;
    rsp_fire  = 1'b0;
    case (state)
      ST_IDLE: begin
        ex_ready_o = 1'b1;
        accept     = ex_valid_i;
        start_mem  = ex_valid_i && is_mem && !al_misalign;
        if (start_mem) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        dreq_valid_o = 1'b1;
        if (dreq_ready_i) state_nxt = ST_RSP;
      end
      ST_RSP: begin
        rsp_fire = drsp_valid_i;
        if (drsp_valid_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Request fields and response-phase operands, captured at acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      dreq_we_o    <= 1'b0;
      dreq_addr_o  <= '0;
      dreq_wdata_o <= '0;
      dreq_wstrb_o <= '0;
      lat_load     <= 1'b0;
      lat_size     <= SZ_B;
      lat_uns      <= 1'b0;
      lat_off      <= '0;
      lat_ena      <= 1'b0;
      lat_raddr    <= '0;
    end else if (start_mem) begin
      dreq_we_o    <= (op == OP_STORE);
      dreq_addr_o  <= mem_addr_i & ~ADDR_W'(STRB_W - 1);
      dreq_wdata_o <= al_wdata;
      dreq_wstrb_o <= al_wstrb;
      lat_load     <= (op == OP_LOAD);
      lat_size     <= mem_size_e'(mem_size_i);
      lat_uns      <= mem_unsigned_i;
      lat_off      <= mem_addr_i[OFF_W-1:0];
      lat_ena      <= rd_w_ena_i;
      lat_raddr    <= rd_w_addr_i;
    end
  end

  // Output register towards WB; wb_valid_o is a one-cycle pulse per retirement.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_o  <= 1'b0;
      rd_w_ena_o  <= 1'b0;
      rd_w_addr_o <= '0;
      rd_w_data_o <= '0;
      misalign_o  <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      if (accept && !is_mem) begin
        wb_valid_o  <= 1'b1;
        rd_w_ena_o  <= rd_w_ena_i;
        rd_w_addr_o <= rd_w_addr_i;
        rd_w_data_o <= rd_w_data_i;
        misalign_o  <= 1'b0;
      end else if (accept && al_misalign) begin
        wb_valid_o  <= 1'b1;
        rd_w_ena_o  <= 1'b0;
        rd_w_addr_o <= rd_w_addr_i;
        rd_w_data_o <= '0;
        misalign_o  <= 1'b1;
      end else if (rsp_fire) begin
        wb_valid_o  <= 1'b1;
        rd_w_ena_o  <= lat_load ? lat_ena : 1'b0;
        rd_w_addr_o <= lat_raddr;
        rd_w_data_o <= lat_load ? al_rdata : '0;
        misalign_o  <= 1'b0;
      end
    end
  end

endmodule
